mw_addsub_seq: RTL
==================

Name: mw_addsub_seq

Overview:
- Multi-word add/subtract sequencer that time-shares one instance of the 32-bit carry-skip adder `cska32` (ports Cout, Sum, A, B, Cin).
- Computes WORDS×32-bit sums/differences one 32-bit limb per cycle, LSB limb first, chaining carry through a register.
- Sits between a wide-operand producer and consumer with valid/ready handshakes on both sides.

Parameters:
- WORDS, 4, number of 32-bit limbs; operand width W = 32*WORDS; legal range 2..16.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op_sub  input  1  0 = add, 1 = subtract.
- a  input  W  operand A, unsigned or two's complement.
- b  input  W  operand B.
- cin  input  1  carry-in for add; ignored for subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- cout  output  1  carry-out of the top limb (subtract: 1 = no borrow, i.e. A >= B unsigned).
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset:
  - state = IDLE.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0, busy = 0.
  - Limb index = 0, carry register = 0, operand registers = 0.
  - in_ready = 1 (decoded from IDLE).
- Arithmetic:
  - Effective B = op_sub ? ~b : b.
  - Limb-0 carry-in = op_sub ? 1 : cin.
  - Limb k uses A[32k+31:32k], effective B limb, and the carry register; adder Sum is written to sum[32k+31:32k]; adder Cout is written to the carry register.
  - Result equals (a + effB + c0) mod 2^W; cout = bit W of that sum.
  - ovf = (a[W-1] == effB[W-1]) && (sum[W-1] != a[W-1]), evaluated on the final limb.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid: register a, effB, c0, reset limb index to 0, go to RUN.
  - sum is not cleared on accept; it is overwritten limb by limb.
- FSM RUN:
  - in_ready = 0.
  - Each cycle process one limb and increment the index.
  - After the limb WORDS-1 edge, latch cout and ovf, set out_valid = 1, go to DONE.
- FSM DONE:
  - out_valid = 1.
  - sum, cout, ovf held stable while out_ready = 0.
  - On out_ready: out_valid = 0 at the next edge, go to IDLE.
- Timing:
  - Accept at edge t; out_valid rises at edge t+WORDS.
  - Minimum spacing between accepts is WORDS+2 cycles. There is no accept in the cycle of the out_ready handshake, even if in_valid is high.
- in_valid/in_ready:
  - in_valid while in_ready = 0 is ignored; the requester must hold it.
  - Inputs a, b, op_sub and cin are sampled only at accept; later changes have no effect.
- Reset mid-operation (RUN or DONE): immediate abort, all outputs return to reset values, no partial result is presented.
- WORDS limb index counter width = clog2(WORDS); it must not wrap within an operation.

Test Plan (WORDS=4 unless stated):
1. Carry chain: a=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, cin=0, add → sum=128'h0000_0001_0000_0000_0000_0000_0000_0000, cout=0, ovf=0. out_valid exactly 4 cycles after accept; busy high throughout.
2. Wrap: a=all ones, b=0, cin=1, add → sum=0, cout=1, ovf=0. Signed add a=128'h7FFF…F, b=1 → sum=128'h8000…0, ovf=1, cout=0.
3. Subtract:
   - a=0, b=1 → sum=all ones, cout=0, ovf=0.
   - a=128'h8000…0, b=1 → sum=128'h7FFF…F, cout=1, ovf=1.
   - a=5, b=5, cin=1 → sum=0, cout=1 (cin ignored).
4. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and a new operand → out_valid, sum, cout and ovf stable; in_ready=0; no second accept. Raise out_ready → out_valid low next edge, in_ready high; second op accepted the following cycle.
5. Reset mid-RUN: drop rst_n asynchronously after 2 limbs → sum=0, out_valid=0, busy=0, in_ready=1 immediately. A fresh op after release completes correctly.
6. Random: 10000 ops with mixed add/sub and random out_ready stalls; WORDS=4 and WORDS=2 builds → every {cout, sum, ovf} matches a behavioural model computing a+effB+c0.

Source files
------------

// File: rtl/mw_addsub_seq_if.sv
// Handshake bundle between a wide-operand producer/consumer and the
// multi-word add/subtract sequencer.
interface mw_addsub_seq_if #(parameter int WORDS = 4);
    localparam int W = 32 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    // Sequencer side
    modport slave (
        input  in_valid, op_sub, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

    // Producer/consumer side
    modport master (
        output in_valid, op_sub, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/mw_addsub_seq.sv
// Multi-word add/subtract sequencer: one shared 32-bit carry-skip adder
// walks the operands LSB limb first, carry chained through a register.

// 32-bit carry-skip adder built from eight 4-bit ripple blocks. A block
// whose bits all propagate forwards its incoming carry directly.
module cska32 (
    output logic        Cout,
    output logic [31:0] Sum,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin
);
    logic [31:0] p;

    // Ripple inside each block, skip mux between blocks
    always_comb begin
        logic blk_c;
        logic rc;
        p     = A ^ B;
        Sum   = '0;
        blk_c = Cin;
        for (int g = 0; g < 8; g++) begin
            rc = blk_c;
            for (int i = 0; i < 4; i++) begin
                Sum[4*g+i] = p[4*g+i] ^ rc;
                rc         = (A[4*g+i] & B[4*g+i]) | (p[4*g+i] & rc);
            end
            blk_c = (&p[4*g +: 4]) ? blk_c : rc;
        end
        Cout = blk_c;
    end
endmodule

module mw_addsub_seq #(
    parameter int WORDS = 4
) (
    input logic            clk,
    input logic            rst_n,
    mw_addsub_seq_if.slave bus
);
    localparam int W  = 32 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [WORDS-1:0][31:0] a_r;
    logic [WORDS-1:0][31:0] b_r;     // already inverted for subtract
    logic [WORDS-1:0][31:0] sum_r;
    logic [IW-1:0]          idx;
    logic                   carry;
    logic                   cout_r;
    logic                   ovf_r;
    logic                   out_valid_r;

    logic [31:0]            limb_a;
    logic [31:0]            limb_b;
    logic [31:0]            add_s;
    logic                   add_co;
    logic                   last;

    assign limb_a = a_r[idx];
    assign limb_b = b_r[idx];
    assign last   = (idx == IW'(WORDS - 1));

    cska32 u_add (
        .Cout (add_co),
        .Sum  (add_s),
        .A    (limb_a),
        .B    (limb_b),
        .Cin  (carry)
    );

    // Sequencer FSM: accept, one limb per cycle, then hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.op_sub ? ~bus.b : bus.b;
                        carry <= bus.op_sub | bus.cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[idx] <= add_s;
                    carry      <= add_co;
                    if (last) begin
                        // Top limb decides carry-out and signed overflow
                        cout_r      <= add_co;
                        ovf_r       <= (a_r[WORDS-1][31] == b_r[WORDS-1][31]) &&
                                       (add_s[31] != a_r[WORDS-1][31]);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // No accept on the handshake cycle; IDLE takes the next one
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = W'(sum_r);
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule
